// File: rtl/i2c_multi_addr_checker_if.sv
// rtl/i2c_multi_addr_checker_if.sv - bus, configuration and status bundle for the multi-address I2C checker
interface i2c_multi_addr_checker_if #(
    parameter int NUM_ADDR = 2
);
    localparam int IW = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;

    // synchronised bus lines and byte hand-off from the shift register
    logic                    SDA_sync;
    logic                    SCL_sync;
    logic [7:0]              rx_data;
    logic                    byte_done;

    // per-slot address configuration
    logic [10*NUM_ADDR-1:0]  bus_address;
    logic [NUM_ADDR-1:0]     address_mode;
    logic [NUM_ADDR-1:0]     addr_en;

    // bus events and address-phase verdict
    logic                    start;
    logic                    rstart;
    logic                    stop;
    logic                    bus_busy;
    logic                    ack_req;
    logic                    address_match;
    logic [IW-1:0]           match_index;
    logic                    general_call;
    logic                    rw_mode;

    // master: the side feeding bus samples/config and consuming the verdict
    modport master (
        output SDA_sync, SCL_sync, rx_data, byte_done,
        output bus_address, address_mode, addr_en,
        input  start, rstart, stop, bus_busy, ack_req,
        input  address_match, match_index, general_call, rw_mode
    );

    // slave: the checker itself
    modport slave (
        input  SDA_sync, SCL_sync, rx_data, byte_done,
        input  bus_address, address_mode, addr_en,
        output start, rstart, stop, bus_busy, ack_req,
        output address_match, match_index, general_call, rw_mode
    );
endinterface

// File: rtl/i2c_multi_addr_checker.sv
// rtl/i2c_multi_addr_checker.sv - I2C slave front-end: line filter, START/STOP detect, multi-slot 7/10-bit address decode
module i2c_multi_addr_checker #(
    parameter int NUM_ADDR     = 2,
    parameter int FILTER_DEPTH = 2,
    parameter bit GCALL_EN     = 1'b1
) (
    input  logic                     clk,
    input  logic                     n_rst,
    i2c_multi_addr_checker_if.slave  bus
);
    localparam int IW = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
    // the filter counter reaching this value means FILTER_DEPTH equal samples were seen
    localparam logic [3:0] FD_LAST = 4'(FILTER_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR1,
        ST_ADDR2,
        ST_DATA,
        ST_IGNORE
    } state_t;

    // ---------------- line filter state ----------------
    logic        r_sda_in;
    logic        r_scl_in;
    logic        r_sda_f;
    logic        r_scl_f;
    logic        r_sda_prev;
    logic        r_scl_prev;
    logic [3:0]  r_sda_cnt;
    logic [3:0]  r_scl_cnt;

    // ---------------- decode state ----------------
    state_t                r_state;
    logic                  r_start;
    logic                  r_rstart;
    logic                  r_stop;
    logic                  r_busy;
    logic                  r_ack;
    logic                  r_match;
    logic [IW-1:0]         r_match_index;
    logic                  r_gcall;
    logic                  r_rw;
    logic                  r_tenbit_hold;
    logic [IW-1:0]         r_hold_idx;
    logic [1:0]            r_hold_hi;
    logic [NUM_ADDR-1:0]   r_cand;

    // ---------------- combinational decode ----------------
    logic                  w_start;
    logic                  w_stop;
    logic                  w_hdr10;
    logic                  w_rd10;
    logic                  w_wr10;
    logic                  w_gcall;
    logic                  w_m7_hit;
    logic [IW-1:0]         w_m7_idx;
    logic [NUM_ADDR-1:0]   w_cand;
    logic                  w_m10_hit;
    logic [IW-1:0]         w_m10_idx;
    logic [1:0]            w_m10_hi;

    // Input register plus per-line deglitch: filtered value flips only after FILTER_DEPTH equal new samples
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sda_in   <= 1'b1;
            r_scl_in   <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_f    <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_cnt  <= '0;
            r_scl_cnt  <= '0;
        end else begin
            r_sda_in   <= bus.SDA_sync;
            r_scl_in   <= bus.SCL_sync;
            r_sda_prev <= r_sda_f;
            r_scl_prev <= r_scl_f;

            if (r_sda_in == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == FD_LAST) begin
                r_sda_f   <= r_sda_in;
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 4'd1;
            end

            if (r_scl_in == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == FD_LAST) begin
                r_scl_f   <= r_scl_in;
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 4'd1;
            end
        end
    end

    // SDA edges while SCL has been stably high are START (falling) or STOP (rising)
    assign w_start = r_scl_f && r_scl_prev &&  r_sda_prev && !r_sda_f;
    assign w_stop  = r_scl_f && r_scl_prev && !r_sda_prev &&  r_sda_f;

    // First-byte classification: 10-bit header (11110xx), repeated-START read of the held 10-bit slot
    assign w_hdr10 = (bus.rx_data[7:3] == 5'b11110);
    assign w_rd10  = w_hdr10 && bus.rx_data[0] && r_tenbit_hold && (bus.rx_data[2:1] == r_hold_hi);
    assign w_wr10  = w_hdr10 && !bus.rx_data[0];
    assign w_gcall = GCALL_EN && (bus.rx_data == 8'h00);

    // Lowest enabled 7-bit slot whose address equals the received 7-bit address
    always_comb begin
        w_m7_hit = 1'b0;
        w_m7_idx = '0;
        for (int i = NUM_ADDR - 1; i >= 0; i--) begin
            if (bus.addr_en[i] && !bus.address_mode[i] &&
                (bus.bus_address[10*i +: 7] == bus.rx_data[7:1])) begin
                w_m7_hit = 1'b1;
                w_m7_idx = IW'(i);
            end
        end
    end

    // Enabled 10-bit slots whose upper two address bits agree with the header byte
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < NUM_ADDR; i++) begin
            w_cand[i] = bus.addr_en[i] && bus.address_mode[i] &&
                        (bus.bus_address[10*i + 8 +: 2] == bus.rx_data[2:1]);
        end
    end

    // Lowest surviving candidate whose low address byte equals the second byte
    always_comb begin
        w_m10_hit = 1'b0;
        w_m10_idx = '0;
        w_m10_hi  = '0;
        for (int i = NUM_ADDR - 1; i >= 0; i--) begin
            if (r_cand[i] && (bus.bus_address[10*i +: 8] == bus.rx_data)) begin
                w_m10_hit = 1'b1;
                w_m10_idx = IW'(i);
                w_m10_hi  = bus.bus_address[10*i + 8 +: 2];
            end
        end
    end

    // Address-phase FSM with registered event pulses and match status; START/STOP override any byte
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= ST_IDLE;
            r_start       <= 1'b0;
            r_rstart      <= 1'b0;
            r_stop        <= 1'b0;
            r_busy        <= 1'b0;
            r_ack         <= 1'b0;
            r_match       <= 1'b0;
            r_match_index <= '0;
            r_gcall       <= 1'b0;
            r_rw          <= 1'b0;
            r_tenbit_hold <= 1'b0;
            r_hold_idx    <= '0;
            r_hold_hi     <= '0;
            r_cand        <= '0;
        end else begin
            r_start  <= 1'b0;
            r_rstart <= 1'b0;
            r_stop   <= 1'b0;
            r_ack    <= 1'b0;

            if (w_stop) begin
                r_state       <= ST_IDLE;
                r_stop        <= 1'b1;
                r_busy        <= 1'b0;
                r_match       <= 1'b0;
                r_gcall       <= 1'b0;
                r_rw          <= 1'b0;
                r_tenbit_hold <= 1'b0;
                r_cand        <= '0;
            end else if (w_start) begin
                r_state  <= ST_ADDR1;
                r_start  <= 1'b1;
                r_rstart <= r_busy;
                r_busy   <= 1'b1;
                r_match  <= 1'b0;
                r_gcall  <= 1'b0;
            end else if (bus.byte_done) begin
                case (r_state)
                    ST_ADDR1: begin
                        if (w_rd10) begin
                            // 10-bit read after repeated START: reuse the slot won in the write handshake
                            r_state       <= ST_DATA;
                            r_ack         <= 1'b1;
                            r_match       <= 1'b1;
                            r_match_index <= r_hold_idx;
                            r_rw          <= 1'b1;
                        end else begin
                            r_tenbit_hold <= 1'b0;
                            if (w_wr10) begin
                                r_cand <= w_cand;
                                if (|w_cand) begin
                                    r_state <= ST_ADDR2;
                                    r_ack   <= 1'b1;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end else if (w_m7_hit) begin
                                r_state       <= ST_DATA;
                                r_ack         <= 1'b1;
                                r_match       <= 1'b1;
                                r_match_index <= w_m7_idx;
                                r_rw          <= bus.rx_data[0];
                            end else if (w_gcall) begin
                                r_state <= ST_DATA;
                                r_ack   <= 1'b1;
                                r_gcall <= 1'b1;
                                r_rw    <= 1'b0;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR2: begin
                        if (w_m10_hit) begin
                            r_state       <= ST_DATA;
                            r_ack         <= 1'b1;
                            r_match       <= 1'b1;
                            r_match_index <= w_m10_idx;
                            r_rw          <= 1'b0;
                            r_tenbit_hold <= 1'b1;
                            r_hold_idx    <= w_m10_idx;
                            r_hold_hi     <= w_m10_hi;
                        end else begin
                            r_state <= ST_IGNORE;
                        end
                    end
                    default: begin
                        // IDLE, DATA and IGNORE do not evaluate bytes
                    end
                endcase
            end
        end
    end

    assign bus.start         = r_start;
    assign bus.rstart        = r_rstart;
    assign bus.stop          = r_stop;
    assign bus.bus_busy      = r_busy;
    assign bus.ack_req       = r_ack;
    assign bus.address_match = r_match;
    assign bus.match_index   = r_match_index;
    assign bus.general_call  = r_gcall;
    assign bus.rw_mode       = r_rw;
endmodule

// File: tb/tb_i2c_multi_addr_checker.sv
// tb/tb_i2c_multi_addr_checker.sv - self-checking bench for i2c_multi_addr_checker
module tb_i2c_multi_addr_checker;
    localparam int NA     = 2;
    localparam int FD     = 2;
    localparam bit GC     = 1'b1;
    localparam int IW     = (NA > 1) ? $clog2(NA) : 1;
    localparam int SETTLE = FD + 4;
    localparam int P_IDLE = 0, P_A1 = 1, P_A2 = 2, P_DONE = 3;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    i2c_multi_addr_checker_if #(.NUM_ADDR(NA)) bus ();

    i2c_multi_addr_checker #(
        .NUM_ADDR(NA), .FILTER_DEPTH(FD), .GCALL_EN(GC)
    ) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_start = 0, cnt_rstart = 0, cnt_stop = 0;

    always @(negedge clk) begin
        if (bus.start)  cnt_start++;
        if (bus.rstart) cnt_rstart++;
        if (bus.stop)   cnt_stop++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // configuration image and reference model of the addressing rules
    logic [9:0] cfg_addr [NA];
    logic       cfg_mode [NA];
    logic       cfg_en   [NA];

    bit         m_busy, m_hold, m_match, m_gc, m_rw, exp_ack;
    int         m_phase, m_idx, m_hold_slot;
    logic [1:0] m_hold_hi;
    int         m_cands[$];

    task automatic apply_cfg();
        for (int i = 0; i < NA; i++) begin
            bus.bus_address[10*i +: 10] = cfg_addr[i];
            bus.address_mode[i]         = cfg_mode[i];
            bus.addr_en[i]              = cfg_en[i];
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_hold = 0; m_match = 0; m_gc = 0; m_rw = 0;
        m_phase = P_IDLE; m_idx = 0; m_hold_slot = 0; m_hold_hi = 2'b00;
        m_cands.delete();
    endtask

    task automatic model_start();
        m_busy = 1; m_phase = P_A1; m_match = 0; m_gc = 0;
    endtask

    task automatic model_byte(input logic [7:0] rx);
        int found;
        exp_ack = 1'b0;
        if (m_phase == P_A1) begin
            m_phase = P_DONE;
            if (rx[7:3] == 5'b11110 && rx[0] && m_hold && rx[2:1] == m_hold_hi) begin
                exp_ack = 1; m_match = 1; m_idx = m_hold_slot; m_rw = 1;
            end else begin
                m_hold = 0;
                if (rx[7:3] == 5'b11110 && !rx[0]) begin
                    m_cands.delete();
                    for (int i = 0; i < NA; i++)
                        if (cfg_en[i] && cfg_mode[i] && cfg_addr[i][9:8] == rx[2:1]) m_cands.push_back(i);
                    if (m_cands.size() != 0) begin
                        m_phase = P_A2; exp_ack = 1;
                    end
                end else begin
                    found = -1;
                    for (int i = 0; i < NA; i++)
                        if (found < 0 && cfg_en[i] && !cfg_mode[i] && cfg_addr[i][6:0] == rx[7:1]) found = i;
                    if (found >= 0) begin
                        exp_ack = 1; m_match = 1; m_idx = found; m_rw = rx[0];
                    end else if (GC && rx == 8'h00) begin
                        exp_ack = 1; m_gc = 1; m_rw = 0;
                    end
                end
            end
        end else if (m_phase == P_A2) begin
            m_phase = P_DONE;
            foreach (m_cands[k]) begin
                if (!exp_ack && cfg_addr[m_cands[k]][7:0] == rx) begin
                    exp_ack = 1; m_match = 1; m_idx = m_cands[k]; m_rw = 0;
                    m_hold = 1; m_hold_slot = m_cands[k]; m_hold_hi = cfg_addr[m_cands[k]][9:8];
                end
            end
        end
    endtask

    function automatic logic [7:0] pick_byte();
        int s;
        s = $urandom_range(0, NA - 1);
        if (m_phase == P_A1) begin
            case ($urandom_range(0, 4))
                0: return 8'($urandom);
                1: return {cfg_addr[s][6:0], 1'($urandom)};
                2: return {5'b11110, cfg_addr[s][9:8], 1'b0};
                3: return {5'b11110, (m_hold ? m_hold_hi : 2'($urandom)), 1'b1};
                default: return 8'h00;
            endcase
        end else if (m_phase == P_A2 && $urandom_range(0, 3) != 0) begin
            return cfg_addr[s][7:0];
        end
        return 8'($urandom);
    endfunction

    // bus stimulus: each line change is held long enough to pass the filter
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_start();
        bus.SDA_sync = 1'b1; wait_cycles(SETTLE);
        bus.SCL_sync = 1'b1; wait_cycles(SETTLE);
        bus.SDA_sync = 1'b0; wait_cycles(SETTLE);
        bus.SCL_sync = 1'b0; wait_cycles(SETTLE);
    endtask

    task automatic drive_stop();
        bus.SDA_sync = 1'b0; wait_cycles(SETTLE);
        bus.SCL_sync = 1'b1; wait_cycles(SETTLE);
        bus.SDA_sync = 1'b1; wait_cycles(SETTLE);
    endtask

    task automatic send_byte(input logic [7:0] rx);
        bus.rx_data   = rx;
        bus.byte_done = 1'b1;
        @(negedge clk);
        bus.byte_done = 1'b0;
    endtask

    task automatic test_reset();
        bus.SDA_sync = 1'b1; bus.SCL_sync = 1'b1; bus.rx_data = 8'h00; bus.byte_done = 1'b0;
        cfg_addr[0] = 10'h03A; cfg_mode[0] = 1'b0; cfg_en[0] = 1'b1;
        cfg_addr[1] = 10'h2C5; cfg_mode[1] = 1'b1; cfg_en[1] = 1'b1;
        apply_cfg();
        model_clear();
        n_rst = 1'b0;
        wait_cycles(3);
        n_tests++;
        if ({bus.start, bus.rstart, bus.stop, bus.bus_busy, bus.ack_req, bus.address_match,
             bus.general_call, bus.rw_mode, bus.match_index} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs required all 0");
        end
        n_rst = 1'b1;
        wait_cycles(SETTLE);
        n_tests++;
        if ({bus.bus_busy, bus.address_match, bus.ack_req} !== 3'b000 || cnt_start !== 0 || cnt_stop !== 0) begin
            n_fail++; $display("FAIL reset_idle: got busy/match/ack=%b starts=%0d stops=%0d required 000 0 0",
                               {bus.bus_busy, bus.address_match, bus.ack_req}, cnt_start, cnt_stop);
        end
    endtask

    task automatic test_filter();
        int s0;
        logic seen;
        s0 = cnt_start;
        bus.SDA_sync = 1'b0; @(negedge clk); bus.SDA_sync = 1'b1;
        wait_cycles(SETTLE);
        n_tests++;
        if (cnt_start !== s0 || bus.bus_busy !== 1'b0) begin
            n_fail++; $display("FAIL filter_glitch: got %0d starts busy=%b required 0 starts busy=0", cnt_start - s0, bus.bus_busy);
        end
        // SDA goes low just before the sampling edge E1; the pulse must appear after edge E1+FD+1
        bus.SDA_sync = 1'b0;
        for (int k = 1; k <= FD + 3; k++) begin
            @(negedge clk);
            seen = bus.start;
            n_tests++;
            if (seen !== (k == FD + 2)) begin
                n_fail++; $display("FAIL filter_start_timing k=%0d: got start=%b required %b", k, seen, (k == FD + 2));
            end
        end
        n_tests++;
        if (bus.bus_busy !== 1'b1 || cnt_rstart !== 0) begin
            n_fail++; $display("FAIL filter_busy: got busy=%b rstarts=%0d required busy=1 rstarts=0", bus.bus_busy, cnt_rstart);
        end
        bus.SCL_sync = 1'b0; wait_cycles(SETTLE);
        drive_stop();
    endtask

    task automatic test_7bit();
        int s0, r0, p0;
        s0 = cnt_start; r0 = cnt_rstart; p0 = cnt_stop;
        drive_start();
        n_tests++;
        if (cnt_start - s0 !== 1 || cnt_rstart - r0 !== 0 || bus.bus_busy !== 1'b1) begin
            n_fail++; $display("FAIL 7bit_start: got starts=%0d rstarts=%0d busy=%b required 1 0 1", cnt_start - s0, cnt_rstart - r0, bus.bus_busy);
        end
        send_byte(8'h75);
        n_tests++;
        if ({bus.ack_req, bus.address_match, bus.general_call, bus.rw_mode} !== 4'b1101 || bus.match_index !== IW'(0)) begin
            n_fail++; $display("FAIL 7bit_match: got ack/match/gc/rw=%b idx=%0d required 1101 idx=0",
                               {bus.ack_req, bus.address_match, bus.general_call, bus.rw_mode}, bus.match_index);
        end
        @(negedge clk);
        n_tests++;
        if (bus.ack_req !== 1'b0 || bus.address_match !== 1'b1) begin
            n_fail++; $display("FAIL 7bit_hold: got ack=%b match=%b required ack=0 match=1", bus.ack_req, bus.address_match);
        end
        drive_stop();
        n_tests++;
        if (cnt_stop - p0 !== 1 || {bus.bus_busy, bus.address_match, bus.general_call, bus.rw_mode} !== 4'b0000) begin
            n_fail++; $display("FAIL 7bit_stop: got stops=%0d busy/match/gc/rw=%b required 1 0000",
                               cnt_stop - p0, {bus.bus_busy, bus.address_match, bus.general_call, bus.rw_mode});
        end
    endtask

    task automatic test_10bit();
        int r0;
        drive_start();
        send_byte(8'hF4);
        n_tests++;
        if ({bus.ack_req, bus.address_match, bus.rw_mode} !== 3'b100) begin
            n_fail++; $display("FAIL 10bit_hdr: got ack/match/rw=%b required 100", {bus.ack_req, bus.address_match, bus.rw_mode});
        end
        send_byte(8'hC5);
        n_tests++;
        if ({bus.ack_req, bus.address_match, bus.rw_mode} !== 3'b110 || bus.match_index !== IW'(1)) begin
            n_fail++; $display("FAIL 10bit_low: got ack/match/rw=%b idx=%0d required 110 idx=1",
                               {bus.ack_req, bus.address_match, bus.rw_mode}, bus.match_index);
        end
        r0 = cnt_rstart;
        drive_start();
        n_tests++;
        if (cnt_rstart - r0 !== 1 || bus.address_match !== 1'b0) begin
            n_fail++; $display("FAIL 10bit_rstart: got rstarts=%0d match=%b required 1 0", cnt_rstart - r0, bus.address_match);
        end
        send_byte(8'hF5);
        n_tests++;
        if ({bus.ack_req, bus.address_match, bus.rw_mode} !== 3'b111 || bus.match_index !== IW'(1)) begin
            n_fail++; $display("FAIL 10bit_read: got ack/match/rw=%b idx=%0d required 111 idx=1",
                               {bus.ack_req, bus.address_match, bus.rw_mode}, bus.match_index);
        end
        drive_stop();
        r0 = cnt_rstart;
        drive_start();
        send_byte(8'hF5);
        n_tests++;
        if ({bus.ack_req, bus.address_match} !== 2'b00 || cnt_rstart - r0 !== 0) begin
            n_fail++; $display("FAIL 10bit_read_after_stop: got ack/match=%b rstarts=%0d required 00 0",
                               {bus.ack_req, bus.address_match}, cnt_rstart - r0);
        end
        send_byte(8'h75);
        n_tests++;
        if ({bus.ack_req, bus.address_match} !== 2'b00) begin
            n_fail++; $display("FAIL ignore_state: got ack/match=%b required 00", {bus.ack_req, bus.address_match});
        end
        drive_stop();
    endtask

    task automatic test_gcall();
        drive_start();
        send_byte(8'h00);
        n_tests++;
        if ({bus.ack_req, bus.address_match, bus.general_call, bus.rw_mode} !== 4'b1010) begin
            n_fail++; $display("FAIL gcall: got ack/match/gc/rw=%b required 1010",
                               {bus.ack_req, bus.address_match, bus.general_call, bus.rw_mode});
        end
        drive_stop();
        n_tests++;
        if (bus.general_call !== 1'b0) begin
            n_fail++; $display("FAIL gcall_stop: got gc=%b required 0", bus.general_call);
        end
        cfg_en[0] = 1'b0; apply_cfg();
        drive_start();
        send_byte(8'h74);
        n_tests++;
        if ({bus.ack_req, bus.address_match} !== 2'b00) begin
            n_fail++; $display("FAIL disabled_slot: got ack/match=%b required 00", {bus.ack_req, bus.address_match});
        end
        drive_stop();
        cfg_en[0] = 1'b1; apply_cfg();
    endtask

    task automatic test_coincident_stop();
        drive_start();
        bus.SCL_sync = 1'b1; wait_cycles(SETTLE);
        bus.SDA_sync = 1'b1;
        repeat (FD + 1) @(negedge clk);
        bus.rx_data = 8'h75; bus.byte_done = 1'b1;
        @(negedge clk);
        bus.byte_done = 1'b0;
        n_tests++;
        if ({bus.stop, bus.ack_req, bus.address_match, bus.bus_busy} !== 4'b1000) begin
            n_fail++; $display("FAIL coincident_stop: got stop/ack/match/busy=%b required 1000",
                               {bus.stop, bus.ack_req, bus.address_match, bus.bus_busy});
        end
        wait_cycles(SETTLE);
    endtask

    task automatic test_async_reset();
        int s0;
        drive_start();
        send_byte(8'h75);
        n_tests++;
        if (bus.address_match !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_match: got match=%b required 1", bus.address_match);
        end
        bus.SDA_sync = 1'b1; wait_cycles(SETTLE);
        bus.SCL_sync = 1'b1; wait_cycles(SETTLE);
        #2 n_rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.start, bus.rstart, bus.stop, bus.bus_busy, bus.ack_req, bus.address_match,
             bus.general_call, bus.rw_mode, bus.match_index} !== '0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b match=%b rw=%b required all outputs 0",
                               bus.bus_busy, bus.address_match, bus.rw_mode);
        end
        @(negedge clk);
        n_rst = 1'b1;
        s0 = cnt_start;
        wait_cycles(SETTLE);
        send_byte(8'h75);
        n_tests++;
        if ({bus.ack_req, bus.address_match} !== 2'b00 || cnt_start !== s0) begin
            n_fail++; $display("FAIL post_reset_no_start: got ack/match=%b starts=%0d required 00 0",
                               {bus.ack_req, bus.address_match}, cnt_start - s0);
        end
        model_clear();
    endtask

    task automatic test_random();
        int nsub, nbytes, s0, r0, p0;
        bit exp_rs;
        logic [7:0] rx;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NA; i++) begin
                cfg_mode[i] = 1'($urandom_range(0, 1));
                cfg_en[i]   = ($urandom_range(0, 3) != 0);
                cfg_addr[i] = 10'($urandom);
            end
            if ($urandom_range(0, 2) == 0) cfg_addr[NA-1] = cfg_addr[0];
            apply_cfg();
            nsub = $urandom_range(1, 3);
            for (int s = 0; s < nsub; s++) begin
                s0 = cnt_start; r0 = cnt_rstart;
                exp_rs = m_busy;
                drive_start();
                model_start();
                n_tests++;
                if (cnt_start - s0 !== 1 || cnt_rstart - r0 !== int'(exp_rs)) begin
                    n_fail++; $display("FAIL rand_start it=%0d: got starts=%0d rstarts=%0d required 1 %0d",
                                       it, cnt_start - s0, cnt_rstart - r0, exp_rs);
                end
                nbytes = $urandom_range(1, 3);
                for (int b = 0; b < nbytes; b++) begin
                    rx = pick_byte();
                    send_byte(rx);
                    model_byte(rx);
                    n_tests++;
                    if ({bus.ack_req, bus.address_match, bus.general_call, bus.rw_mode} !== {exp_ack, m_match, m_gc, m_rw} ||
                        (m_match && bus.match_index !== IW'(m_idx))) begin
                        n_fail++; $display("FAIL rand_byte it=%0d rx=%h: got ack/match/gc/rw=%b idx=%0d required %b idx=%0d",
                                           it, rx, {bus.ack_req, bus.address_match, bus.general_call, bus.rw_mode},
                                           bus.match_index, {exp_ack, m_match, m_gc, m_rw}, m_idx);
                    end
                end
            end
            p0 = cnt_stop;
            drive_stop();
            model_clear();
            n_tests++;
            if (cnt_stop - p0 !== 1 || {bus.bus_busy, bus.address_match, bus.general_call} !== 3'b000) begin
                n_fail++; $display("FAIL rand_stop it=%0d: got stops=%0d busy/match/gc=%b required 1 000",
                                   it, cnt_stop - p0, {bus.bus_busy, bus.address_match, bus.general_call});
            end
        end
    endtask

    initial begin
        test_reset();
        test_filter();
        test_7bit();
        test_10bit();
        test_gcall();
        test_coincident_stop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
